uart: RTL and testbench
=======================

UART -- requirements
Module: uart

Interface
REQ-001 SHALL have parameter DELAY_FRAMES, default 234, meaning clock cycles per serial bit (27 MHz / 115200 baud); minimum legal value 4.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port uart_rx  input  1  serial receive line, idle high, 8N1, LSB first.
REQ-005 SHALL have port uart_tx  output  1  serial transmit line, idle high, 8N1, LSB first.
REQ-006 SHALL have port led  output  6  active-low LED bank showing the last received byte.
REQ-007 SHALL have port btn  input  1  active-low pushbutton requesting message transmission.
REQ-008 SHALL follow the already-decided clocking: one clock, clk; reset rst is synchronous and active-high.

Function
REQ-009 SHALL pass uart_rx and btn each through a 2-flop synchronizer; all decisions use synchronized values (2-cycle input latency).
REQ-010 SHALL implement RX FSM states RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH with a bit-cycle counter and 3-bit bit index.
REQ-011 RX_IDLE: on synchronized rx = 0, go RX_START and clear counter.
REQ-012 RX_START: after DELAY_FRAMES/2 (integer division) cycles re-sample rx; if 1 (glitch) return RX_IDLE, else go RX_DATA, counter cleared, bit index 0.
REQ-013 RX_DATA: every DELAY_FRAMES cycles sample rx into data bit [index], LSB first; after bit 7 go RX_STOP.
REQ-014 RX_STOP: after DELAY_FRAMES cycles sample rx; if 1 latch received byte and return RX_IDLE; if 0 (framing error) discard byte, leave led unchanged, go RX_WAIT_HIGH.
REQ-015 RX_WAIT_HIGH: remain until rx = 1, then RX_IDLE.
REQ-016 led SHALL equal bitwise NOT of received byte bits [5:0], updated on the cycle after a valid stop bit; held otherwise.
REQ-017 A new start bit SHALL be accepted on the first cycle back in RX_IDLE (back-to-back frames supported).
REQ-018 TX: on synchronized btn = 0 while TX idle, transmit fixed 7-byte message "Hello" CR LF (0x48 0x65 0x6C 0x6C 0x6F 0x0D 0x0A), bytes back-to-back.
REQ-019 Each TX frame SHALL be start bit 0, 8 data bits LSB first, stop bit 1, each held exactly DELAY_FRAMES cycles (10*DELAY_FRAMES cycles per byte).
REQ-020 TX FSM states TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DEBOUNCE; after the last stop bit go TX_DEBOUNCE and return to TX_IDLE only once btn = 1 (one message per press).
REQ-021 btn release mid-message SHALL NOT abort the message.
REQ-022 RX and TX SHALL operate independently and concurrently.

Reset
REQ-023 While rst = 1 at a clk edge: RX and TX FSMs to idle, counters and indices 0, received byte 0x00, led = 6'b111111, uart_tx = 1, synchronizers set to 1.
REQ-024 Reset mid-frame SHALL abort RX (byte discarded) and TX (line returns high next cycle); message restarts from byte 0 on the next press.

Configuration
REQ-025 Macro UART_TX_EN: when defined, the transmitter (REQ-018..REQ-021) is compiled in.
REQ-026 Without UART_TX_EN: no TX logic, uart_tx tied to 1, btn ignored; RX unaffected.

Verification (DELAY_FRAMES = 8, clk period 2 time units)
REQ-027 Reset then idle: rst high 2 cycles -> led = 111111, uart_tx = 1 constant.
REQ-028 RX 0x61: start 0, bits 1,0,0,0,0,1,1,0, stop 1, 8 cycles each -> led = 011110 after stop sampling, stable thereafter.
REQ-029 Glitch: rx low 2 cycles then high -> FSM returns to RX_IDLE, led unchanged.
REQ-030 Framing error: frame of 0x3F with stop bit 0 -> led unchanged; next valid 0x01 frame -> led = 111110.
REQ-031 TX (UART_TX_EN defined): btn low 20 cycles then high -> uart_tx emits 0x48..0x0A, 70 bit periods of 8 cycles, then idles high; no repeat while btn held.
REQ-032 Reset mid-RX: rst pulsed during bit 4 of a frame -> led = 111111, next full frame 0x2A received correctly, led = 010101.

Source files
------------

// File: rtl/uart.sv
// 8N1 UART: receiver drives an active-low LED bank with the last good byte; an
// optional transmitter (macro UART_TX_EN) sends "Hello\r\n" once per button press.
module uart #(
    parameter int unsigned DELAY_FRAMES = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [5:0] led,
    input  logic       btn
);

    localparam int unsigned CNT_W = $clog2(DELAY_FRAMES);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DELAY_FRAMES / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t        r_rx_state, w_rx_state_nxt;
    logic             r_rx_meta, r_rx_sync;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]       r_rx_idx, w_rx_idx_nxt;
    logic [7:0]       r_rx_shift, w_rx_shift_nxt;
    logic [5:0]       r_led, w_led_nxt;
    logic             w_rx;

    assign w_rx = r_rx_sync;
    assign led  = r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_led      <= 6'b111111;
        end else begin
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_led      <= w_led_nxt;
        end
    end

    // Bits shift in from the top, so after eight samples bit 0 sits in r_rx_shift[0].
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + CNT_W'(1);
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_shift_nxt = r_rx_shift;
        w_led_nxt      = r_led;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (!w_rx) w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (r_rx_cnt == HALF_M1) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_idx_nxt   = '0;
                    w_rx_state_nxt = w_rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == FULL_M1) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {w_rx, r_rx_shift[7:1]};
                    w_rx_idx_nxt   = r_rx_idx + 3'd1;
                    if (r_rx_idx == 3'd7) w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == FULL_M1) begin
                    w_rx_cnt_nxt = '0;
                    if (w_rx) begin
                        w_led_nxt      = ~r_rx_shift[5:0];
                        w_rx_state_nxt = RX_IDLE;
                    end else begin
                        w_rx_state_nxt = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                w_rx_cnt_nxt = '0;
                if (w_rx) w_rx_state_nxt = RX_IDLE;
            end
            default: begin
                w_rx_cnt_nxt   = '0;
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

`ifdef UART_TX_EN
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_DEBOUNCE
    } tx_state_t;

    tx_state_t        r_tx_state, w_tx_state_nxt;
    logic             r_btn_meta, r_btn_sync;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]       r_tx_bit, w_tx_bit_nxt;
    logic [2:0]       r_tx_byte, w_tx_byte_nxt;
    logic             r_tx, w_tx_nxt;
    logic [7:0]       w_tx_data;
    logic [2:0]       w_tx_bit_inc;

    function automatic logic [7:0] msg_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    msg_byte = 8'h48;
            3'd1:    msg_byte = 8'h65;
            3'd2:    msg_byte = 8'h6C;
            3'd3:    msg_byte = 8'h6C;
            3'd4:    msg_byte = 8'h6F;
            3'd5:    msg_byte = 8'h0D;
            default: msg_byte = 8'h0A;
        endcase
    endfunction

    assign w_tx_data    = msg_byte(r_tx_byte);
    assign w_tx_bit_inc = r_tx_bit + 3'd1;
    assign uart_tx      = r_tx;

    always_ff @(posedge clk) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_meta <= 1'b1;
            r_btn_sync <= 1'b1;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_btn_meta <= btn;
            r_btn_sync <= r_btn_meta;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // The line level for the next bit is chosen at the boundary so each bit lasts exactly DELAY_FRAMES.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + CNT_W'(1);
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_byte_nxt  = r_tx_byte;
        w_tx_nxt       = r_tx;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = '0;
                w_tx_nxt     = 1'b1;
                if (!r_btn_sync) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_byte_nxt  = '0;
                    w_tx_nxt       = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == FULL_M1) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_nxt       = w_tx_data[0];
                    w_tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == FULL_M1) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_nxt       = 1'b1;
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_bit_nxt = w_tx_bit_inc;
                        w_tx_nxt     = w_tx_data[w_tx_bit_inc];
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == FULL_M1) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_byte == 3'd6) begin
                        w_tx_state_nxt = TX_DEBOUNCE;
                    end else begin
                        w_tx_byte_nxt  = r_tx_byte + 3'd1;
                        w_tx_nxt       = 1'b0;
                        w_tx_state_nxt = TX_START;
                    end
                end
            end
            TX_DEBOUNCE: begin
                w_tx_cnt_nxt = '0;
                if (r_btn_sync) w_tx_state_nxt = TX_IDLE;
            end
            default: begin
                w_tx_cnt_nxt   = '0;
                w_tx_nxt       = 1'b1;
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
    end
`else
    logic w_unused_btn;

    assign w_unused_btn = btn;
    assign uart_tx      = 1'b1;
`endif

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart with DELAY_FRAMES = 8; transmitter checks follow UART_TX_EN.
module tb_uart;

    localparam int unsigned DF = 8;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       uart_rx = 1'b1;
    logic       btn     = 1'b1;
    logic       uart_tx;
    logic [5:0] led;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] msg [7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};

    uart #(.DELAY_FRAMES(DF)) dut (
        .clk    (clk),
        .rst    (rst),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .led    (led),
        .btn    (btn)
    );

    always #1 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (DF) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (DF) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (DF) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic expect_tx_idle(input int n, input string tag);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

`ifdef UART_TX_EN
    // Samples each of the 70 bit periods at its midpoint and checks every 10-bit frame.
    task automatic tx_message(input int release_at, input string tag);
        int         w;
        int         elapsed;
        logic [9:0] fr;
        w = 0;
        while (uart_tx !== 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_start"}, 32'(w < 50), 32'd1);
        if (w >= 50) return;
        elapsed = w;
        fr = '0;
        for (int k = 0; k < 70; k++) begin
            for (int j = 0; j < 8; j++) begin
                if (j == 4) fr[k % 10] = uart_tx;
                @(negedge clk);
                elapsed++;
                if (release_at > 0 && elapsed == release_at) btn = 1'b1;
            end
            if (k % 10 == 9) check($sformatf("%s_byte%0d", tag, k / 10), 32'(fr), 32'({1'b1, msg[k / 10], 1'b0}));
        end
    endtask
`endif

    initial begin
        logic [7:0] part;
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("reset_led", 32'(led), 32'h3F);
        check("reset_tx", 32'(uart_tx), 32'd1);
        expect_tx_idle(20, "idle_tx");
        check("idle_led", 32'(led), 32'h3F);

        send_frame(8'h61, 1'b1);
        check("rx_61", 32'(led), 32'(6'b011110));
        idle(30);
        check("rx_61_hold", 32'(led), 32'(6'b011110));

        uart_rx = 1'b0;
        idle(2);
        uart_rx = 1'b1;
        idle(20);
        check("glitch", 32'(led), 32'(6'b011110));

        send_frame(8'h3F, 1'b0);
        check("framing_err", 32'(led), 32'(6'b011110));
        idle(20);
        send_frame(8'h01, 1'b1);
        check("rx_01", 32'(led), 32'(6'b111110));

        send_frame(8'h2A, 1'b1);
        check("b2b_a", 32'(led), 32'(6'b010101));
        send_frame(8'h01, 1'b1);
        check("b2b_b", 32'(led), 32'(6'b111110));
        idle(10);

        part = 8'h55;
        uart_rx = 1'b0;
        idle(DF);
        for (int i = 0; i < 4; i++) begin
            uart_rx = part[i];
            idle(DF);
        end
        uart_rx = part[4];
        idle(4);
        check("mid_frame_led", 32'(led), 32'(6'b111110));
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        uart_rx = 1'b1;
        check("rst_mid_rx", 32'(led), 32'h3F);
        idle(20);
        send_frame(8'h2A, 1'b1);
        check("rx_after_rst", 32'(led), 32'(6'b010101));
        idle(10);

`ifdef UART_TX_EN
        btn = 1'b0;
        tx_message(20, "tx_msg");
        expect_tx_idle(100, "tx_idle_after");

        btn = 1'b0;
        tx_message(0, "tx_held");
        expect_tx_idle(200, "tx_no_repeat");
        btn = 1'b1;
        expect_tx_idle(20, "tx_release");

        btn = 1'b0;
        idle(30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        btn = 1'b1;
        check("tx_rst_abort", 32'(uart_tx), 32'd1);
        expect_tx_idle(30, "tx_rst_idle");
        btn = 1'b0;
        tx_message(20, "tx_restart");
        expect_tx_idle(20, "tx_restart_idle");
`else
        btn = 1'b0;
        expect_tx_idle(200, "tx_disabled");
        btn = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
